// File: rtl/jtoutrun_pkg.sv
// Shared constants for the Out Run shared work RAM arbiter.
package jtoutrun_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC_A = 2'd1;
  localparam logic [1:0] ST_ACC_B = 2'd2;
  localparam logic [1:0] ST_REL   = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [7:0] TOUT_DEF = 8'd255;
endpackage

// File: rtl/jtoutrun_shram_port.sv
// Per-CPU side of the arbiter: pending/served tracking, level ok and read data hold.
module jtoutrun_shram_port (
  input  logic        rst,
  input  logic        clk,
  input  logic        i_cs,
  input  logic        i_cmpl,
  input  logic        i_load,
  input  logic [15:0] i_data,
  output logic        o_pend,
  output logic        o_ok,
  output logic [15:0] o_dout
);
  logic r_served;

  // served blocks a re-grant until the CPU drops cs for at least one cycle
  assign o_pend = i_cs & ~r_served;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_served <= 1'b0;
      o_ok     <= 1'b0;
      o_dout   <= 16'h0;
    end else if (!i_cs) begin
      r_served <= 1'b0;
      o_ok     <= 1'b0;
    end else if (i_cmpl) begin
      r_served <= 1'b1;
      o_ok     <= 1'b1;
      if (i_load) o_dout <= i_data;
    end
  end
endmodule

// File: rtl/jtoutrun_shram_arb.sv
// Main/sub 68000 arbiter onto one SDRAM-facing work RAM port, round-robin on contention.
module jtoutrun_shram_arb
  import jtoutrun_pkg::*;
#(
  parameter int         AW   = 14,
  parameter logic [7:0] TOUT = TOUT_DEF
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          a_cs,
  input  logic [AW:1]   a_addr,
  input  logic [1:0]    a_dsn,
  input  logic          a_rnw,
  input  logic [15:0]   a_din,
  output logic [15:0]   a_dout,
  output logic          a_ok,
  input  logic          b_cs,
  input  logic [AW:1]   b_addr,
  input  logic [1:0]    b_dsn,
  input  logic          b_rnw,
  input  logic [15:0]   b_din,
  output logic [15:0]   b_dout,
  output logic          b_ok,
  output logic          mem_cs,
  output logic [AW:1]   mem_addr,
  output logic [1:0]    mem_dsn,
  output logic          mem_we,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ok,
  output logic          err
);
  logic [1:0]  r_st;
  logic        r_last, r_abort, r_rnw;
  logic [7:0]  r_cnt;
  logic        w_pend_a, w_pend_b, w_gnt_a, w_acc, w_port, w_cs;
  logic        w_tout, w_fin, w_cmpl, w_load;
  logic [15:0] w_data;

  assign w_gnt_a = w_pend_a & (~w_pend_b | (r_last == PORT_B));
  assign w_acc   = (r_st == ST_ACC_A) | (r_st == ST_ACC_B);
  assign w_port  = (r_st == ST_ACC_B) ? PORT_B : PORT_A;
  assign w_cs    = (w_port == PORT_B) ? b_cs : a_cs;
  // a real mem_ok wins over a coincident timeout
  assign w_tout  = ~mem_ok & (r_cnt == TOUT - 8'd1);
  assign w_fin   = w_acc & (mem_ok | w_tout);
  // a requester that let go of cs during the access never sees it complete
  assign w_cmpl  = w_fin & w_cs & ~r_abort;
  assign w_load  = r_rnw | w_tout;
  assign w_data  = w_tout ? 16'hffff : mem_dout;

  jtoutrun_shram_port u_port_a (
    .rst(rst), .clk(clk), .i_cs(a_cs), .i_cmpl(w_cmpl & (w_port == PORT_A)),
    .i_load(w_load), .i_data(w_data), .o_pend(w_pend_a), .o_ok(a_ok), .o_dout(a_dout)
  );

  jtoutrun_shram_port u_port_b (
    .rst(rst), .clk(clk), .i_cs(b_cs), .i_cmpl(w_cmpl & (w_port == PORT_B)),
    .i_load(w_load), .i_data(w_data), .o_pend(w_pend_b), .o_ok(b_ok), .o_dout(b_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= ST_IDLE;
      r_last   <= PORT_B;
      r_abort  <= 1'b0;
      r_rnw    <= 1'b0;
      r_cnt    <= 8'd0;
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      mem_dsn  <= 2'b00;
      mem_we   <= 1'b0;
      mem_din  <= 16'h0;
      err      <= 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: if (w_pend_a | w_pend_b) begin
          r_st     <= w_gnt_a ? ST_ACC_A : ST_ACC_B;
          r_cnt    <= 8'd0;
          r_abort  <= 1'b0;
          r_rnw    <= w_gnt_a ? a_rnw : b_rnw;
          mem_cs   <= 1'b1;
          mem_addr <= w_gnt_a ? a_addr : b_addr;
          mem_dsn  <= w_gnt_a ? a_dsn : b_dsn;
          mem_we   <= ~(w_gnt_a ? a_rnw : b_rnw);
          mem_din  <= w_gnt_a ? a_din : b_din;
        end
        ST_ACC_A, ST_ACC_B: begin
          if (!w_cs) r_abort <= 1'b1;
          if (w_fin) begin
            mem_cs <= 1'b0;
            r_last <= w_port;
            r_st   <= ST_REL;
            if (w_tout) err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_st <= ST_IDLE;  // REL: let mem_ok fall before the next grant
      endcase
    end
  end
endmodule

// File: tb/tb_jtoutrun_shram_arb.sv
// Self-checking bench for jtoutrun_shram_arb: vector table, corner sequences, random two-CPU traffic.
module tb_jtoutrun_shram_arb;
  localparam int         AW   = 14;
  localparam logic [7:0] TOUT = 8'd255;

  logic        rst, clk;
  logic        a_cs, a_rnw, a_ok, b_cs, b_rnw, b_ok;
  logic [AW:1] a_addr, b_addr, mem_addr;
  logic [1:0]  a_dsn, b_dsn, mem_dsn;
  logic [15:0] a_din, a_dout, b_din, b_dout, mem_din, mem_dout;
  logic        mem_cs, mem_we, mem_ok, err;

  jtoutrun_shram_arb #(.AW(AW), .TOUT(TOUT)) dut (
    .rst(rst), .clk(clk),
    .a_cs(a_cs), .a_addr(a_addr), .a_dsn(a_dsn), .a_rnw(a_rnw), .a_din(a_din), .a_dout(a_dout), .a_ok(a_ok),
    .b_cs(b_cs), .b_addr(b_addr), .b_dsn(b_dsn), .b_rnw(b_rnw), .b_din(b_din), .b_dout(b_dout), .b_ok(b_ok),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_dsn(mem_dsn), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ok(mem_ok), .err(err)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  int mem_lat = 1;
  bit mem_rand = 0;
  logic [15:0] marr [0:16383];
  logic [15:0] sh   [0:16383];
  int mon_viol = 0, gap_viol = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #2000000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end

  function automatic logic [15:0] initv(input logic [AW:1] a);
    return {2'b10, a} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din, input logic [1:0] dsn);
    logic [15:0] r;
    r = old;
    if (!dsn[1]) r[15:8] = din[15:8];
    if (!dsn[0]) r[7:0]  = din[7:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: mem_ok after cur_lat cycles of mem_cs (lat 0 = never answers)
  initial begin
    int mcnt, cur_lat;
    mcnt = 0; cur_lat = 1; mem_ok = 0; mem_dout = 16'h0;
    for (int i = 0; i < 16384; i++) marr[i] = initv(AW'(i));
    forever begin
      @(posedge clk); #1;
      if (!mem_cs || rst) begin
        mem_ok = 0; mcnt = 0;
      end else if (!mem_ok) begin
        mcnt++;
        if (mcnt == 1) cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        if (cur_lat != 0 && mcnt >= cur_lat) begin
          mem_ok = 1;
          if (mem_we) marr[mem_addr] = merge(marr[mem_addr], mem_din, mem_dsn);
          else        mem_dout = marr[mem_addr];
        end
      end
    end
  end

  // Bus monitor: request fields frozen while mem_cs is high, >=2 idle cycles between accesses
  initial begin
    logic        pcs;
    logic [32:0] pbus;
    int          lowrun;
    bit          seen_hi;
    pcs = 0; pbus = '0; lowrun = 0; seen_hi = 0;
    forever begin
      @(negedge clk);
      if (mem_cs && pcs && {mem_addr, mem_dsn, mem_we, mem_din} != pbus) mon_viol++;
      if (mem_cs && !pcs && seen_hi && lowrun < 2) gap_viol++;
      if (mem_cs) begin seen_hi = 1; lowrun = 0; end else lowrun++;
      pcs = mem_cs; pbus = {mem_addr, mem_dsn, mem_we, mem_din};
    end
  end

  task automatic xfer(input bit p, input bit rnw, input logic [AW:1] addr, input logic [1:0] dsn,
                      input logic [15:0] din, input bit hold, input bit chk,
                      output logic [15:0] dout, output int n, output int t_ok);
    bit got;
    @(posedge clk); #1;
    if (p) begin b_cs = 1; b_rnw = rnw; b_addr = addr; b_dsn = dsn; b_din = din; end
    else   begin a_cs = 1; a_rnw = rnw; a_addr = addr; a_dsn = dsn; a_din = din; end
    n = 0; got = 0;
    while (!got && n < 600) begin
      @(posedge clk); #2; n++;
      if (chk && n == 1) begin
        check("grant_mem_cs", mem_cs, 1);
        check("grant_addr", mem_addr, addr);
        check("grant_we", mem_we, !rnw);
        check("grant_dsn", mem_dsn, dsn);
        if (!rnw) check("grant_din", mem_din, din);
      end
      got = p ? b_ok : a_ok;
    end
    check(p ? "b_ok_wait" : "a_ok_wait", got, 1);
    t_ok = cyc;
    dout = p ? b_dout : a_dout;
    if (hold) begin @(posedge clk); #2; check("ok_hold", p ? b_ok : a_ok, 1); end
    if (p) b_cs = 0; else a_cs = 0;
    @(posedge clk); #2;
    if (hold) check("ok_clear", p ? b_ok : a_ok, 0);
  endtask

  task automatic rnd_port(input bit p, input int cnt);
    logic [AW:1] addr; logic [1:0] dsn; logic [15:0] din, dout; bit rnw; int n, t, k2;
    for (int k = 0; k < cnt; k++) begin
      rnw  = 1'($urandom_range(0, 1));
      addr = (p ? 14'h0300 : 14'h0200) + 14'($urandom_range(0, 15));
      k2   = int'($urandom_range(0, 2));
      dsn  = (k2 == 0) ? 2'b00 : (k2 == 1) ? 2'b01 : 2'b10;
      din  = 16'($urandom);
      xfer(p, rnw, addr, dsn, din, 0, 0, dout, n, t);
      if (rnw) check(p ? "rnd_b_read" : "rnd_a_read", dout, sh[addr]);
      else     sh[addr] = merge(sh[addr], din, dsn);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1; repeat (3) @(posedge clk); #1; rst = 0;
  endtask

  typedef struct {
    logic        p;
    logic        rnw;
    logic [AW:1] addr;
    logic [1:0]  dsn;
    logic [15:0] din;
    int          lat;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [11];

  initial begin
    logic [15:0] da, db, prev, v101, v102, v5;
    int na, nb, ta, tb2;
    bit aok_seen;
    rst = 1; a_cs = 0; b_cs = 0; a_rnw = 1; b_rnw = 1;
    a_addr = '0; b_addr = '0; a_dsn = 0; b_dsn = 0; a_din = 0; b_din = 0;
    for (int i = 0; i < 16384; i++) sh[i] = initv(AW'(i));

    // reset state
    @(posedge clk); #2;
    check("rst_ctl", {a_ok, b_ok, mem_cs, mem_we, err, mem_dsn}, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_b_dout", b_dout, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    do_reset();

    // first contention after reset: A wins, B follows one transaction + 2 cycles later
    mem_lat = 2;
    fork
      xfer(0, 1, 14'h0010, 2'b00, 16'h0, 0, 0, da, na, ta);
      xfer(1, 1, 14'h0011, 2'b00, 16'h0, 0, 0, db, nb, tb2);
    join
    check("cont1_a_first", ta < tb2, 1);
    check("cont1_gap", tb2 - ta, mem_lat + 2);
    check("cont1_a_data", da, initv(14'h0010));
    check("cont1_b_data", db, initv(14'h0011));
    // A served last -> B wins the next contention
    xfer(0, 1, 14'h0012, 2'b00, 16'h0, 0, 0, da, na, ta);
    fork
      xfer(0, 1, 14'h0013, 2'b00, 16'h0, 0, 0, da, na, ta);
      xfer(1, 1, 14'h0014, 2'b00, 16'h0, 0, 0, db, nb, tb2);
    join
    check("cont2_b_first", tb2 < ta, 1);
    check("cont2_gap", ta - tb2, mem_lat + 2);
    check("cont2_a_data", da, initv(14'h0013));

    // single-port vectors: latency = mem latency + 1, dout held across writes
    v101 = initv(14'h0101);
    v102 = initv(14'h0102);
    v5   = merge(v101, 16'h00AB, 2'b10);
    tbl[0]  = '{1'b0, 1'b1, 14'h0040, 2'b00, 16'h0000, 1, initv(14'h0040)};
    tbl[1]  = '{1'b0, 1'b0, 14'h0100, 2'b00, 16'h1234, 2, initv(14'h0040)};
    tbl[2]  = '{1'b0, 1'b1, 14'h0100, 2'b00, 16'h0000, 3, 16'h1234};
    tbl[3]  = '{1'b1, 1'b1, 14'h0101, 2'b00, 16'h0000, 1, v101};
    tbl[4]  = '{1'b1, 1'b0, 14'h0101, 2'b10, 16'h00AB, 4, v101};
    tbl[5]  = '{1'b1, 1'b1, 14'h0101, 2'b00, 16'h0000, 2, v5};
    tbl[6]  = '{1'b0, 1'b0, 14'h0102, 2'b01, 16'hCD00, 1, 16'h1234};
    tbl[7]  = '{1'b0, 1'b1, 14'h0102, 2'b00, 16'h0000, 1, {8'hCD, v102[7:0]}};
    tbl[8]  = '{1'b0, 1'b1, 14'h0100, 2'b00, 16'h0000, 4, 16'h1234};
    tbl[9]  = '{1'b1, 1'b0, 14'h0103, 2'b00, 16'hFFFF, 3, v5};
    tbl[10] = '{1'b1, 1'b1, 14'h0103, 2'b00, 16'h0000, 2, 16'hFFFF};
    for (int i = 0; i < 11; i++) begin
      mem_lat = tbl[i].lat;
      xfer(tbl[i].p, tbl[i].rnw, tbl[i].addr, tbl[i].dsn, tbl[i].din, 1, 1, da, na, ta);
      check($sformatf("tbl%0d_lat", i), na, tbl[i].lat + 1);
      check($sformatf("tbl%0d_dout", i), da, tbl[i].exp);
    end

    // A drops cs mid-access: no a_ok, a_dout kept, B granted once A's access drains
    mem_lat = 1;
    xfer(0, 1, 14'h0040, 2'b00, 16'h0, 0, 0, prev, na, ta);
    mem_lat = 5;
    @(posedge clk); #1; a_cs = 1; a_rnw = 1; a_addr = 14'h0070; a_dsn = 2'b00;
    repeat (2) @(posedge clk);
    #1; a_cs = 0;
    aok_seen = 0;
    fork
      xfer(1, 1, 14'h0071, 2'b00, 16'h0, 0, 0, db, nb, tb2);
      for (int k = 0; k < 20; k++) begin @(posedge clk); #2; if (a_ok) aok_seen = 1; end
    join
    check("abort_no_ok", aok_seen, 0);
    check("abort_dout_hold", a_dout, prev);
    check("abort_b_data", db, initv(14'h0071));
    // A occupies mem until its mem_ok (5 cycles), then REL, IDLE, and B's own 5-cycle access
    check("abort_b_lat", nb, 10);

    // memory never answers: timeout completes with ffff and sets sticky err
    mem_lat = 0;
    xfer(0, 1, 14'h0060, 2'b00, 16'h0, 0, 0, da, na, ta);
    check("tout_lat", na, int'(TOUT) + 1);
    check("tout_dout", da, 16'hffff);
    check("tout_err", err, 1);
    mem_lat = 1;
    xfer(1, 1, 14'h0061, 2'b00, 16'h0, 0, 0, db, nb, tb2);
    check("tout_err_sticky", err, 1);
    check("tout_next_data", db, initv(14'h0061));

    // reset in the middle of a B write
    mem_lat = 6;
    @(posedge clk); #1; b_cs = 1; b_rnw = 0; b_addr = 14'h0050; b_dsn = 2'b00; b_din = 16'h5555;
    repeat (3) @(posedge clk);
    #1; check("rstmid_pre_cs", mem_cs, 1);
    #1; rst = 1; b_cs = 0;
    #1;
    check("rstmid_ctl", {a_ok, b_ok, mem_cs, mem_we, err, mem_dsn}, 0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_din", mem_din, 0);
    check("rstmid_a_dout", a_dout, 0);
    check("rstmid_b_dout", b_dout, 0);
    @(posedge clk); #1; rst = 0;
    mem_lat = 1;
    xfer(0, 1, 14'h0040, 2'b00, 16'h0, 1, 1, da, na, ta);
    check("rstmid_idle_lat", na, 2);
    check("rstmid_idle_data", da, initv(14'h0040));
    check("rstmid_no_write", marr[14'h0050], initv(14'h0050));

    // random two-CPU traffic with random memory latency against a shadow memory
    mem_rand = 1;
    fork
      rnd_port(0, 40);
      rnd_port(1, 40);
    join
    mem_rand = 0;

    check("mem_bus_stable", mon_viol, 0);
    check("mem_cs_gap", gap_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
